// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine coin sequencer.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    VEND,
    PAYOUT
  } state_t;

  localparam int unsigned COIN1 = 1;
  localparam int unsigned COIN5 = 5;

endpackage

// File: rtl/vend_edge.sv
// One-bit rising-edge detector. The previous-sample register tracks the live level,
// including while in reset, so a level held through reset never reads as an edge.
module vend_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    prev <= level;
  end

  assign rise = level & ~prev & ~rst;

endmodule

// File: rtl/vend_sequencer.sv
// Coin-credit controller: owns the credit count and sequences the dispenser
// (item/item_ack) and the change hopper (change/hopper_rdy).
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 3,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                P1,
  input  logic                P5,
  input  logic                R,
  input  logic                item_ack,
  input  logic                hopper_rdy,
  output logic                item,
  output logic                change,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] VAL1    = CREDIT_W'(COIN1);
  localparam logic [CREDIT_W-1:0] VAL5    = CREDIT_W'(COIN5);
  localparam logic [CREDIT_W-1:0] ONE     = CREDIT_W'(1);

  logic ev_p1;
  logic ev_p5;
  logic ev_r;

  vend_edge u_edge_p1 (.clk(clk), .rst(rst), .level(P1), .rise(ev_p1));
  vend_edge u_edge_p5 (.clk(clk), .rst(rst), .level(P5), .rise(ev_p5));
  vend_edge u_edge_r  (.clk(clk), .rst(rst), .level(R),  .rise(ev_r));

  state_t              state;
  logic                coin_ev;
  logic                refund_go;
  logic [CREDIT_W-1:0] sum;

  // A simultaneous P1+P5 credits the 5; an R with no credit is treated as absent.
  always_comb begin
    coin_ev   = ev_p1 | ev_p5;
    refund_go = ev_r & (credit != '0);
    sum       = credit + (ev_p5 ? VAL5 : VAL1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      credit   <= '0;
      item     <= 1'b0;
      change   <= 1'b0;
      coin_rej <= 1'b0;
      busy     <= 1'b0;
    end else begin
      change   <= 1'b0;
      coin_rej <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (refund_go) begin
            state    <= PAYOUT;
            busy     <= 1'b1;
            coin_rej <= coin_ev;
          end else if (coin_ev) begin
            coin_rej <= ev_p1 & ev_p5;
            if (sum >= PRICE_C) begin
              state  <= VEND;
              credit <= sum - PRICE_C;
              item   <= 1'b1;
              busy   <= 1'b1;
            end else begin
              credit <= sum;
            end
          end
        end
        VEND: begin
          coin_rej <= coin_ev;
          if (item_ack) begin
            item <= 1'b0;
            if (credit != '0) begin
              state <= PAYOUT;
            end else begin
              state <= COLLECT;
              busy  <= 1'b0;
            end
          end
        end
        PAYOUT: begin
          coin_rej <= coin_ev;
          if (hopper_rdy && credit != '0) begin
            change <= 1'b1;
            credit <= credit - ONE;
            if (credit == ONE) begin
              state <= COLLECT;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios with literal expectations plus a
// randomized run, all cross-checked each cycle against a behavioural credit model.
module tb_vend_sequencer;

  localparam int PRICE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       P1 = 1'b0, P5 = 1'b0, R = 1'b0, item_ack = 1'b0, hopper_rdy = 1'b0;
  logic       item, change, coin_rej, busy;
  logic [3:0] credit;

  int checks = 0;
  int passes = 0;

  vend_sequencer #(.PRICE(PRICE), .CREDIT_W(4)) dut (
    .clk(clk), .rst(rst), .P1(P1), .P5(P5), .R(R),
    .item_ack(item_ack), .hopper_rdy(hopper_rdy),
    .item(item), .change(change), .coin_rej(coin_rej), .busy(busy), .credit(credit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: phase 0 = collecting, 1 = item pending, 2 = paying change.
  int m_credit = 0;
  int m_phase = 0;
  bit m_item = 0, m_change = 0, m_rej = 0, m_valid = 0;
  bit l1 = 0, l5 = 0, lr = 0;

  initial begin
    bit e1, e5, er;
    forever begin
      @(posedge clk);
      e1 = P1 && !l1;
      e5 = P5 && !l5;
      er = R && !lr;
      l1 = P1; l5 = P5; lr = R;
      if (rst) begin
        m_credit = 0; m_phase = 0; m_item = 0; m_change = 0; m_rej = 0; m_valid = 1;
      end else if (m_valid) begin
        m_change = 0;
        m_rej    = 0;
        if (m_phase == 0) begin
          if (er && m_credit > 0) begin
            m_rej   = e1 || e5;
            m_phase = 2;
          end else if (e1 || e5) begin
            m_rej    = e1 && e5;
            m_credit = m_credit + (e5 ? 5 : 1);
            if (m_credit >= PRICE) begin
              m_credit = m_credit - PRICE;
              m_phase  = 1;
              m_item   = 1;
            end
          end
        end else if (m_phase == 1) begin
          m_rej = e1 || e5;
          if (item_ack) begin
            m_item  = 0;
            m_phase = (m_credit > 0) ? 2 : 0;
          end
        end else begin
          m_rej = e1 || e5;
          if (hopper_rdy && m_credit > 0) begin
            m_change = 1;
            m_credit = m_credit - 1;
            if (m_credit == 0) m_phase = 0;
          end
        end
      end
      #1;
      if (m_valid) begin
        chk("model_credit", int'(credit), m_credit);
        chk("model_item", int'(item), int'(m_item));
        chk("model_change", int'(change), int'(m_change));
        chk("model_coin_rej", int'(coin_rej), int'(m_rej));
        chk("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
      end
    end
  end

  // Apply one cycle of input levels just after a falling edge; return at the next falling edge.
  task automatic drive(input bit p1, input bit p5, input bit r, input bit ack, input bit rdy);
    P1 = p1; P5 = p5; R = r; item_ack = ack; hopper_rdy = rdy;
    @(negedge clk);
  endtask

  initial begin
    bit lv1, lv5, lvr;
    @(negedge clk);
    @(negedge clk);
    chk("reset_credit", int'(credit), 0);
    chk("reset_item", int'(item), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_change", int'(change), 0);
    rst = 1'b0;

    // 1: single P5 -> vend with 2 change units
    drive(0, 1, 0, 0, 0);
    chk("s1_credit", int'(credit), 2);
    chk("s1_item", int'(item), 1);
    drive(0, 0, 0, 1, 1);
    chk("s1_item_drop", int'(item), 0);
    chk("s1_no_change_yet", int'(change), 0);
    drive(0, 0, 0, 0, 1);
    chk("s1_change1", int'(change), 1);
    chk("s1_credit1", int'(credit), 1);
    drive(0, 0, 0, 0, 1);
    chk("s1_change2", int'(change), 1);
    chk("s1_credit0", int'(credit), 0);
    chk("s1_idle", int'(busy), 0);
    drive(0, 0, 0, 0, 1);
    chk("s1_change_end", int'(change), 0);

    // 2: three P1 coins spaced two cycles apart
    drive(1, 0, 0, 0, 0);
    chk("s2_credit1", int'(credit), 1);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("s2_credit2", int'(credit), 2);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("s2_item", int'(item), 1);
    chk("s2_credit0", int'(credit), 0);
    drive(0, 0, 0, 1, 1);
    chk("s2_item_drop", int'(item), 0);
    chk("s2_collect", int'(busy), 0);
    drive(0, 0, 0, 0, 1);
    chk("s2_no_change", int'(change), 0);

    // 3: P1, P1, refund
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1);
    chk("s3_busy", int'(busy), 1);
    chk("s3_credit", int'(credit), 2);
    drive(0, 0, 0, 0, 1);
    chk("s3_change1", int'(change), 1);
    drive(0, 0, 0, 0, 1);
    chk("s3_change2", int'(change), 1);
    chk("s3_credit0", int'(credit), 0);
    chk("s3_no_item", int'(item), 0);

    // 4: P1+P5 together, then P1 during VEND
    drive(1, 1, 0, 0, 0);
    chk("s4_rej", int'(coin_rej), 1);
    chk("s4_credit", int'(credit), 2);
    chk("s4_item", int'(item), 1);
    drive(0, 0, 0, 0, 0);
    chk("s4_rej_pulse", int'(coin_rej), 0);
    drive(1, 0, 0, 0, 0);
    chk("s4_vend_rej", int'(coin_rej), 1);
    chk("s4_vend_credit", int'(credit), 2);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("s4_paid", int'(credit), 0);

    // 5: credit 3 with the hopper stalled
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("s5_credit", int'(credit), 3);
    chk("s5_item", int'(item), 1);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("s5_stall_change", int'(change), 0);
      chk("s5_stall_credit", int'(credit), 3);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      chk("s5_pay_change", int'(change), 1);
      chk("s5_pay_credit", int'(credit), 2 - i);
    end
    drive(0, 0, 0, 0, 1);
    chk("s5_done", int'(change), 0);

    // 6: reset mid-payout with P1 held through reset
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    chk("s6_first_change", int'(change), 1);
    rst = 1'b1;
    drive(1, 0, 0, 0, 1);
    chk("s6_rst_credit", int'(credit), 0);
    chk("s6_rst_change", int'(change), 0);
    chk("s6_rst_item", int'(item), 0);
    chk("s6_rst_busy", int'(busy), 0);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0);
    chk("s6_held_credit", int'(credit), 0);
    chk("s6_held_rej", int'(coin_rej), 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("s6_alive", int'(credit), 1);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("s6_refund", int'(credit), 0);

    // Randomized run, checked only by the model
    lv1 = 0; lv5 = 0; lvr = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) lv1 = ~lv1;
      if ($urandom_range(0, 5) == 0) lv5 = ~lv5;
      if ($urandom_range(0, 7) == 0) lvr = ~lvr;
      rst = ($urandom_range(0, 149) == 0);
      drive(lv1, lv5, lvr, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
